// File: rtl/rotator_pkg.sv
`default_nettype none
// rotator_pkg: shared types and constants for the rotator and the rotation aligner.
// Revision: 1.0
package rotator_pkg;

    localparam int ROT_WIDTH = 100;

    localparam logic [1:0] ROT_HOLD  = 2'b00;
    localparam logic [1:0] ROT_RIGHT = 2'b01;
    localparam logic [1:0] ROT_LEFT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rot_step.sv
`default_nettype none
// rot_step: combinational single-bit left/right rotate selected by the rotator ena encoding.
// Revision: 1.0
module rot_step
    import rotator_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH
) (
    input  logic [1:0]       ena,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = word;
        case (ena)
            ROT_LEFT:  result = {word[WIDTH-2:0], word[WIDTH-1]};
            ROT_RIGHT: result = {word[0], word[WIDTH-1:1]};
            ROT_HOLD:  result = word;
            default:   result = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rotation_aligner.sv
`default_nettype none
// rotation_aligner: serially recovers the right-rotation offset of a word against a reference pattern.
// Revision: 1.0
module rotation_aligner
    import rotator_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] word_in,
    input  logic [WIDTH-1:0] pattern,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             found,
    output logic [CNT_W-1:0] offset,
    output logic [WIDTH-1:0] aligned
);

    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] rotated;
    logic [CNT_W-1:0] k;
    logic             primed;
    logic             eq;

    rot_step #(.WIDTH(WIDTH)) u_step (
        .ena    (ROT_LEFT),
        .word   (shreg),
        .result (rotated)
    );

    // eq always holds the registered compare of the current shreg, so the
    // first SEARCH cycle only primes it and each rotation refreshes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            pat_q     <= '0;
            k         <= '0;
            primed    <= 1'b0;
            eq        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            found     <= 1'b0;
            offset    <= '0;
            aligned   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= word_in;
                        pat_q    <= pattern;
                        k        <= '0;
                        primed   <= 1'b0;
                        eq       <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (abort) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else if (!primed) begin
                        primed <= 1'b1;
                        eq     <= (shreg == pat_q);
                    end else if (eq) begin
                        found     <= 1'b1;
                        offset    <= k;
                        aligned   <= shreg;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (k != K_LAST) begin
                        shreg <= rotated;
                        k     <= k + 1'b1;
                        eq    <= (rotated == pat_q);
                    end else begin
                        // Final rotation restores the original word for the no-match result.
                        shreg     <= rotated;
                        aligned   <= rotated;
                        found     <= 1'b0;
                        offset    <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rotation_aligner.sv
`default_nettype none
// tb_rotation_aligner: directed bench for rotation_aligner at WIDTH=8 and WIDTH=100.
// Revision: 1.0
module tb_rotation_aligner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start8 = 1'b0, abort8 = 1'b0, out_ready8 = 1'b1;
    logic [7:0] word8 = '0, pat8 = '0;
    logic       in_ready8, valid8, found8;
    logic [2:0] offset8;
    logic [7:0] aligned8;

    rotation_aligner #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .in_ready(in_ready8),
        .word_in(word8), .pattern(pat8), .abort(abort8), .out_valid(valid8),
        .out_ready(out_ready8), .found(found8), .offset(offset8), .aligned(aligned8)
    );

    // WIDTH=100 instance
    logic        start100 = 1'b0, abort100 = 1'b0, out_ready100 = 1'b1;
    logic [99:0] word100 = '0, pat100 = '0;
    logic        in_ready100, valid100, found100;
    logic [6:0]  offset100;
    logic [99:0] aligned100;

    rotation_aligner #(.WIDTH(100)) dut100 (
        .clk(clk), .reset(reset), .start(start100), .in_ready(in_ready100),
        .word_in(word100), .pattern(pat100), .abort(abort100), .out_valid(valid100),
        .out_ready(out_ready100), .found(found100), .offset(offset100), .aligned(aligned100)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Transaction-level model of the WIDTH=8 instance
    logic       m_busy = 1'b0, m_valid = 1'b0, m_found = 1'b0;
    logic [2:0] m_off = '0;
    logic [7:0] m_al = '0;
    logic       e_found;
    logic [2:0] e_off;
    logic [7:0] e_al;
    int         m_cnt = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0; m_valid = 1'b0; m_found = 1'b0; m_off = '0; m_al = '0;
        end else if (m_valid) begin
            if (out_ready8) m_valid = 1'b0;
        end else if (m_busy) begin
            if (abort8) begin
                m_busy = 1'b0;
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0; m_valid = 1'b1;
                    m_found = e_found; m_off = e_off; m_al = e_al;
                end
            end
        end else if (start8) begin
            e_found = 1'b0; e_off = '0; e_al = word8; m_cnt = 9;
            for (int j = 7; j >= 0; j--) begin
                if (rotl8(word8, j) == pat8) begin
                    e_found = 1'b1; e_off = 3'(j); e_al = pat8; m_cnt = j + 2;
                end
            end
            m_busy = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("in_ready8", in_ready8, !(m_busy || m_valid));
        chk("out_valid8", valid8, m_valid);
        if (m_valid || reset) begin
            chk("found8", found8, m_found);
            chk("offset8", offset8, m_off);
            chk("aligned8", aligned8, m_al);
        end
    end

    task automatic run8(input logic [7:0] w, input logic [7:0] p, input logic ef,
                        input logic [2:0] eo, input logic [7:0] ea, input int elat);
        int n;
        word8 = w; pat8 = p; start8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        n = 0;
        while (!valid8 && n < 40) begin
            @(posedge clk); #1 n++;
        end
        chk("latency8", n, elat);
        chk("lit_found8", found8, ef);
        chk("lit_offset8", offset8, eo);
        chk("lit_aligned8", aligned8, ea);
        @(posedge clk); #1;
        chk("post_hs_valid8", valid8, 1'b0);
        chk("post_hs_ready8", in_ready8, 1'b1);
    endtask

    initial begin
        int n;
        logic [99:0] v;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready8, 1'b1);
        chk("rst_valid", valid8, 1'b0);
        chk("rst_aligned", aligned8, 8'h00);
        reset = 1'b0;
        @(posedge clk); #1;

        run8(8'b1000_0001, 8'b0000_0011, 1'b1, 3'd1, 8'h03, 3);
        run8(8'hFF, 8'hFE, 1'b0, 3'd0, 8'hFF, 9);
        run8(8'h55, 8'hAA, 1'b1, 3'd1, 8'hAA, 3);
        run8(8'h00, 8'h00, 1'b1, 3'd0, 8'h00, 2);

        // WIDTH=100: 888888888 rotated right by 5
        v = 100'd888888888;
        word100 = {v[4:0], v[99:5]}; pat100 = v; start100 = 1'b1;
        @(posedge clk); #1 start100 = 1'b0;
        n = 0;
        while (!valid100 && n < 200) begin
            @(posedge clk); #1 n++;
        end
        chk("latency100", n, 7);
        chk("found100", found100, 1'b1);
        chk("offset100", offset100, 7'd5);
        chk("aligned100", aligned100, v);
        @(posedge clk); #1;
        chk("post_hs_ready100", in_ready100, 1'b1);

        // Abort with start also held while busy
        word8 = 8'h04; pat8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1 abort8 = 1'b1;
        @(posedge clk); #1 abort8 = 1'b0; start8 = 1'b0;
        chk("abort_in_ready", in_ready8, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_valid", valid8, 1'b0);
        end
        run8(8'h04, 8'h01, 1'b1, 3'd6, 8'h01, 8);

        // Backpressure, with start driven during the handshake
        word8 = 8'h03; pat8 = 8'h0C; out_ready8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        n = 0;
        while (!valid8 && n < 40) begin
            @(posedge clk); #1 n++;
        end
        chk("bp_latency", n, 4);
        start8 = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("bp_valid", valid8, 1'b1);
            chk("bp_in_ready", in_ready8, 1'b0);
            chk("bp_offset", offset8, 3'd2);
            chk("bp_aligned", aligned8, 8'h0C);
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        chk("bp_hs_valid", valid8, 1'b0);
        chk("bp_hs_ready", in_ready8, 1'b1);
        @(posedge clk); #1;
        chk("bp_start_ignored", in_ready8, 1'b1);

        // Asynchronous reset mid-search
        word8 = 8'h04; pat8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        @(posedge clk);
        @(posedge clk); #2 reset = 1'b1;
        #1;
        chk("arst_in_ready", in_ready8, 1'b1);
        chk("arst_valid", valid8, 1'b0);
        chk("arst_found", found8, 1'b0);
        chk("arst_offset", offset8, 3'd0);
        chk("arst_aligned", aligned8, 8'h00);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        run8(8'h5A, 8'h5A, 1'b1, 3'd0, 8'h5A, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rotation_aligner.md
Name: rotation_aligner

Overview:
- Receive-side companion to the left/right rotator: takes a word that was rotated by an unknown amount and recovers the right-rotation offset against a known reference pattern.
- Works serially: captures the word, then rotates it left one bit per cycle and compares it with the pattern until it matches or all offsets are exhausted.
- Returns the offset, a found flag and the realigned word over a valid/ready result handshake.
- Sits downstream of the rotator in the same datapath and shares its 100-bit default width.

Parameters:
- WIDTH, 100, word width in bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH), width of the offset counter and of the offset output.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a search; accepted only when in_ready=1.
- in_ready  output  1  high in IDLE only.
- word_in  input  WIDTH  rotated word; sampled on the accepted start.
- pattern  input  WIDTH  reference word; sampled on the accepted start.
- abort  input  1  cancels an in-progress search.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- found  output  1  1 = a matching offset exists.
- offset  output  CNT_W  smallest k such that rotl(word_in,k) == pattern, i.e. word_in was rotated right by k.
- aligned  output  WIDTH  captured word rotated left by offset.

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - in_ready=1, out_valid=0, found=0, offset=0, aligned=0.
  - All internal registers cleared.
- States: IDLE, SEARCH, DONE (one-hot or binary; encoding is not visible at ports).
- IDLE:
  - in_ready=1.
  - On start=1, capture word_in into the shift register and pattern into the pattern register, set k=0, go to SEARCH.
- SEARCH: each cycle, compare shift register with pattern register (combinational compare, registered decision).
  - Match: go to DONE; offset=k, found=1, aligned=shift register. Shift register does not rotate.
  - Mismatch and k < WIDTH-1: rotate shift register left by 1 (bit WIDTH-1 wraps to bit 0); k <= k+1.
  - Mismatch and k == WIDTH-1: rotate once more so that aligned equals the original word_in; go to DONE with found=0, offset=0.
  - abort=1: return to IDLE with no result. abort takes priority over a match in the same cycle. abort is ignored in IDLE and DONE.
- DONE:
  - out_valid=1. found, offset and aligned are held stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: with start accepted on edge 0, a match at offset k gives out_valid=1 after edge k+2. The no-match case gives out_valid=1 after edge WIDTH+1.
- Simultaneous events:
  - start while not IDLE is ignored; no queueing.
  - start in the same cycle as the DONE handshake is ignored; in_ready is low that cycle.
- Periodic patterns: the smallest matching k is reported. An all-zero word with an all-zero pattern gives k=0.
- Reset mid-SEARCH or mid-DONE: immediate return to reset values; no result is emitted.
- Widths: k is CNT_W bits and never exceeds WIDTH-1; no wrap of k is possible.

Decomposition:
- Package rotator_pkg:
  - state enum {IDLE, SEARCH, DONE}.
  - Rotator ena encodings ROT_HOLD=2'b00, ROT_RIGHT=2'b01, ROT_LEFT=2'b10, shared with the rotator and its benches.
  - Default width constant ROT_WIDTH=100.
- One natural sub-module: rot_step, a parameterised combinational single-bit left/right rotate, reusable by the rotator.

Test Plan:
- WIDTH=8, word_in=8'b1000_0001, pattern=8'b0000_0011, start at edge 0, out_ready=1 -> out_valid after edge 3; found=1, offset=1, aligned=8'h03; in_ready high again after the handshake.
- WIDTH=100, word_in = 888888888 rotated right 5 (rotator ena=ROT_RIGHT for 5 cycles), pattern=888888888 -> found=1, offset=5, aligned=888888888, out_valid after edge 7.
- WIDTH=8, word_in=8'hFF, pattern=8'hFE -> found=0, offset=0, aligned=8'hFF, out_valid after edge 9.
- WIDTH=8, search with expected offset 6; abort at edge 3, with start=1 also driven while busy -> return to IDLE with no out_valid; the busy-time start has no effect; a new start then yields offset 6.
- Backpressure: result ready with out_ready=0 for 4 cycles -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE on the next edge.
- reset asserted asynchronously mid-SEARCH (between edges) -> outputs go to reset values immediately; after release, a start with word_in==pattern gives offset=0, found=1.
